// File: rtl/dft_capture_pkg.sv
// ----------------------------------------------------------------------------
// dft_capture_pkg : shared types for the DFT output capture stage.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dft_capture_pkg;

  localparam int DFT_FRAME_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } cap_state_e;

  typedef logic [63:0] dft_beat_t;

endpackage

`default_nettype wire

// File: rtl/dft_out_capture_if.sv
// ----------------------------------------------------------------------------
// dft_out_capture_if : core stream, host handshake and read port bundle.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dft_out_capture_if
  import dft_capture_pkg::*;
#(
  parameter int FRAME_CYCLES = DFT_FRAME_CYCLES,
  parameter int AW           = $clog2(FRAME_CYCLES)
);
  logic            next_out;
  logic [15:0]     Y0;
  logic [15:0]     Y1;
  logic [15:0]     Y2;
  logic [15:0]     Y3;
  logic            frame_ack;
  logic            clr_err;
  logic [AW-1:0]   rd_addr;
  dft_beat_t       rd_data;
  logic            frame_valid;
  logic            busy;
  logic            overrun_err;
  logic [15:0]     frame_cnt;

  modport master (
    output next_out, Y0, Y1, Y2, Y3, frame_ack, clr_err, rd_addr,
    input  rd_data, frame_valid, busy, overrun_err, frame_cnt
  );

  modport slave (
    input  next_out, Y0, Y1, Y2, Y3, frame_ack, clr_err, rd_addr,
    output rd_data, frame_valid, busy, overrun_err, frame_cnt
  );
endinterface

`default_nettype wire

// File: rtl/dft_capture_ram.sv
// ----------------------------------------------------------------------------
// dft_capture_ram : simple dual-port frame buffer, sync write, registered read.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dft_capture_ram
  import dft_capture_pkg::*;
#(
  parameter int DEPTH = DFT_FRAME_CYCLES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic    clk,
  input  wire logic    we_i,
  input  wire [AW-1:0] waddr_i,
  input  dft_beat_t    wdata_i,
  input  wire [AW-1:0] raddr_i,
  output dft_beat_t    rdata_o
);

  dft_beat_t mem_q [DEPTH];
  dft_beat_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dft_out_capture.sv
// ----------------------------------------------------------------------------
// dft_out_capture : captures one DFT output frame and serves it to the host.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dft_out_capture
  import dft_capture_pkg::*;
#(
  parameter int FRAME_CYCLES = DFT_FRAME_CYCLES,
  parameter int AW           = $clog2(FRAME_CYCLES)
) (
  input  wire logic         clk,
  input  wire logic         reset,
  dft_out_capture_if.slave  bus
);

  localparam logic [AW-1:0] LAST_BEAT = AW'(FRAME_CYCLES - 1);

  cap_state_e    state_q;
  logic [AW-1:0] beat_q;
  logic          frame_valid_q;
  logic          busy_q;
  logic          overrun_q;
  logic [15:0]   frame_cnt_q;
  logic          rd_en_q;

  logic          ram_we;
  logic          addr_ok;
  dft_beat_t     ram_rdata;

  // A restart pulse carries no beat, so nothing is written on that cycle.
  assign ram_we = (state_q == CAPTURE) && !bus.next_out;

  generate
    if ((1 << AW) == FRAME_CYCLES) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_cmp
      assign addr_ok = ({1'b0, bus.rd_addr} < (AW+1)'(FRAME_CYCLES));
    end
  endgenerate

  dft_capture_ram #(
    .DEPTH (FRAME_CYCLES),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (beat_q),
    .wdata_i ({bus.Y0, bus.Y1, bus.Y2, bus.Y3}),
    .raddr_i (bus.rd_addr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
      rd_en_q       <= 1'b0;
    end else begin
      rd_en_q <= frame_valid_q && addr_ok;
      // Clear first so a coincident overrun below takes priority.
      if (bus.clr_err) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (bus.next_out) begin
            state_q <= CAPTURE;
            beat_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (bus.next_out) begin
            overrun_q <= 1'b1;
            beat_q    <= '0;
          end else if (beat_q == LAST_BEAT) begin
            state_q       <= HOLD;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b1;
            frame_cnt_q   <= frame_cnt_q + 16'd1;
          end else begin
            beat_q <= beat_q + AW'(1);
          end
        end
        HOLD: begin
          if (bus.frame_ack) begin
            frame_valid_q <= 1'b0;
            if (bus.next_out) begin
              state_q <= CAPTURE;
              beat_q  <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (bus.next_out) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_data     = rd_en_q ? ram_rdata : '0;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = busy_q;
  assign bus.overrun_err = overrun_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dft_out_capture.sv
// ----------------------------------------------------------------------------
// tb_dft_out_capture : scoreboard bench for the DFT output capture stage.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dft_out_capture;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dft_out_capture_if #(.FRAME_CYCLES(32)) bus ();
  dft_out_capture_if #(.FRAME_CYCLES(20)) bus2 ();

  dft_out_capture #(.FRAME_CYCLES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Non-power-of-two depth so an out-of-range address is expressible.
  dft_out_capture #(.FRAME_CYCLES(20)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus2.next_out  = bus.next_out;
  assign bus2.Y0        = bus.Y0;
  assign bus2.Y1        = bus.Y1;
  assign bus2.Y2        = bus.Y2;
  assign bus2.Y3        = bus.Y3;
  assign bus2.frame_ack = bus.frame_ack;
  assign bus2.clr_err   = bus.clr_err;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mdl   [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word(input int seed, input int b);
    logic [15:0] y0;
    y0 = 16'(seed + b);
    return {y0, y0 + 16'h0100, y0 + 16'h0200, y0 + 16'h0300};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input int seed, input int n, input int start);
    for (int b = start; b < start + n; b++) begin
      {bus.Y0, bus.Y1, bus.Y2, bus.Y3} = word(seed, b);
      mdl[b] = word(seed, b);
      tick();
    end
  endtask

  task automatic pulse_start();
    bus.next_out = 1'b1;
    {bus.Y0, bus.Y1, bus.Y2, bus.Y3} = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    bus.next_out = 1'b0;
  endtask

  task automatic rd(input string tag, input int addr, input logic [63:0] e);
    exp_q.push_back(e);
    bus.rd_addr = 5'(addr);
    tick();
    chk(tag, bus.rd_data, exp_q.pop_front());
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.next_out  = 1'b0;
    bus.frame_ack = 1'b0;
    bus.clr_err   = 1'b0;
    bus.rd_addr   = '0;
    bus2.rd_addr  = '0;
    {bus.Y0, bus.Y1, bus.Y2, bus.Y3} = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_fv",   64'(bus.frame_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy),        64'd0);
    chk("rst_ovr",  64'(bus.overrun_err), 64'd0);
    chk("rst_cnt",  64'(bus.frame_cnt),   64'd0);
    chk("rst_rd",   bus.rd_data,          64'd0);

    // Single frame
    pulse_start();
    chk("f1_busy", 64'(bus.busy), 64'd1);
    beats(0, 31, 0);
    chk("f1_fv_early", 64'(bus.frame_valid), 64'd0);
    beats(0, 1, 31);
    chk("f1_fv",   64'(bus.frame_valid), 64'd1);
    chk("f1_busy0", 64'(bus.busy),       64'd0);
    chk("f1_cnt",  64'(bus.frame_cnt),   64'd1);
    rd("f1_a5",  5,  64'h0005_0105_0205_0305);
    rd("f1_a0",  0,  mdl[0]);
    rd("f1_a31", 31, mdl[31]);
    chk("d2_fv", 64'(bus2.frame_valid), 64'd1);
    bus2.rd_addr = 5'd25;
    tick();
    chk("d2_oob", bus2.rd_data, 64'd0);
    bus2.rd_addr = 5'd3;
    tick();
    chk("d2_a3", bus2.rd_data, word(0, 3));

    // Overrun in HOLD, then clear
    pulse_start();
    chk("hov_ovr", 64'(bus.overrun_err), 64'd1);
    chk("hov_fv",  64'(bus.frame_valid), 64'd1);
    rd("hov_a0", 0, word(0, 0));
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("hov_clr", 64'(bus.overrun_err), 64'd0);

    // Ack plus new frame together
    bus.frame_ack = 1'b1;
    bus.next_out  = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    bus.next_out  = 1'b0;
    chk("an_busy", 64'(bus.busy),        64'd1);
    chk("an_fv",   64'(bus.frame_valid), 64'd0);
    chk("an_ovr",  64'(bus.overrun_err), 64'd0);
    beats(16'h40, 32, 0);
    chk("an_fv2",  64'(bus.frame_valid), 64'd1);
    chk("an_cnt",  64'(bus.frame_cnt),   64'd2);
    chk("an_ovr2", 64'(bus.overrun_err), 64'd0);
    rd("an_a7", 7, word(16'h40, 7));

    // Plain ack, then read while idle
    ack();
    chk("ack_fv", 64'(bus.frame_valid), 64'd0);
    rd("idle_rd", 7, 64'd0);

    // Restart mid-capture at beat 10
    pulse_start();
    beats(16'h80, 10, 0);
    pulse_start();
    chk("rs_ovr",  64'(bus.overrun_err), 64'd1);
    chk("rs_busy", 64'(bus.busy),        64'd1);
    beats(16'h90, 31, 0);
    chk("rs_fv_early", 64'(bus.frame_valid), 64'd0);
    beats(16'h90, 1, 31);
    chk("rs_fv",  64'(bus.frame_valid), 64'd1);
    chk("rs_cnt", 64'(bus.frame_cnt),   64'd3);
    rd("rs_a0",  0,  word(16'h90, 0));
    rd("rs_a12", 12, word(16'h90, 12));
    ack();

    // Reset mid-capture at beat 15 (overrun still set going in)
    pulse_start();
    beats(16'hA0, 15, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_fv",   64'(bus.frame_valid), 64'd0);
    chk("mr_busy", 64'(bus.busy),        64'd0);
    chk("mr_ovr",  64'(bus.overrun_err), 64'd0);
    chk("mr_cnt",  64'(bus.frame_cnt),   64'd0);
    chk("mr_rd",   bus.rd_data,          64'd0);
    pulse_start();
    beats(16'hC0, 32, 0);
    chk("mr_fv2", 64'(bus.frame_valid), 64'd1);
    chk("mr_cnt2", 64'(bus.frame_cnt),  64'd1);
    rd("mr_a20", 20, word(16'hC0, 20));

    // Frame counter wrap
    ack();
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    chk("wr_pre", 64'(bus.frame_cnt), 64'hFFFF);
    pulse_start();
    beats(16'hE0, 32, 0);
    chk("wr_cnt", 64'(bus.frame_cnt), 64'd0);
    rd("wr_a31", 31, word(16'hE0, 31));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
